serial_staticisor: RTL and testbench
====================================

Name: serial_staticisor

Overview:
- Parametrised successor to the parallel staticisor. It accepts the serial, LSB-first word stream from the store/control path during the scan phase (w_HA=0).
- It assembles one framed word, extracts two configurable fields (line address, function) into a staging register, and transfers them to static outputs on the rising edge of w_HA.
- Outputs hold for the entire action phase.
- Sits between the serial store read-out and line decode / function decode.

Parameters:
WORD_W, 32, bits per serial word (>=2)
LINE_LSB, 0, bit index of line field within word
LINE_W, 5, line field width
FUNC_LSB, 13, bit index of function field
FUNC_W, 3, function field width
(Legal only if LINE_LSB+LINE_W<=WORD_W and FUNC_LSB+FUNC_W<=WORD_W; fields may overlap.)

Ports:
w_CLK  in  1  system clock
w_RST  in  1  asynchronous active-high reset
w_HA  in  1  phase: 0=scan (accept bits), 1=action (hold outputs)
w_BIT_VALID  in  1  serial bit strobe, one bit per asserted cycle
w_BIT  in  1  serial data bit, LSB first
w_SOW  in  1  start-of-word, qualifies bit 0 (sampled with w_BIT_VALID)
w_CAPTURE  in  1  this word is to be staticised (sampled with w_SOW)
b_LINE  out  LINE_W  staticised line field
b_FUNC  out  FUNC_W  staticised function field
w_STAT_VALID  out  1  1-cycle pulse: outputs updated this cycle
w_STAGED  out  1  level: complete word waiting in staging
w_FRAME_ERR  out  1  1-cycle pulse: word aborted
w_NO_WORD  out  1  1-cycle pulse: action began with nothing staged

Behaviour:
- Reset (async, w_RST=1): FSM=IDLE, bit counter=0, shift reg=0, staging=0, staged=0, ha_d=0, all outputs 0. Release is synchronous to w_CLK.
- Registered state: ha_d <= w_HA every cycle. ha_rise = w_HA & ~ha_d. w_HA high at the first clock after reset counts as a rise.
- Bits are accepted only when w_HA=0 and w_BIT_VALID=1. w_BIT_VALID is ignored while w_HA=1.
- FSM IDLE:
  - On an accepted bit with w_SOW=1 and w_CAPTURE=1: shift[0]<=w_BIT, cnt<=1, go SHIFT.
  - Any other accepted bit is discarded.
- FSM SHIFT, on an accepted bit with w_SOW=0: shift[cnt]<=w_BIT, cnt++.
  - If cnt==WORD_W-1 (last bit): staging line <= word[LINE_LSB+:LINE_W], staging func <= word[FUNC_LSB+:FUNC_W], using the completed word including this bit; staged<=1; go IDLE; cnt<=0.
- FSM SHIFT, on an accepted bit with w_SOW=1 (premature frame):
  - w_FRAME_ERR pulses.
  - If w_CAPTURE=1, restart: shift[0]<=w_BIT, cnt<=1, stay SHIFT. Otherwise go IDLE.
  - Existing staging is untouched.
- FSM SHIFT with w_HA=1 (action began mid-word): abort, w_FRAME_ERR pulses, go IDLE, cnt<=0. Staging is untouched.
- Completion of a newer word while staged=1 overwrites staging (latest word wins). staged stays 1.
- On ha_rise:
  - If staged=1: b_LINE/b_FUNC <= staging, w_STAT_VALID=1 for that cycle, staged<=0.
  - If staged=0: outputs unchanged, w_NO_WORD pulses.
  - Latency: updated outputs are visible after the clock edge where w_HA is first sampled high.
- Completion and ha_rise cannot coincide, because bits are ignored while w_HA=1.
- b_LINE/b_FUNC change only on ha_rise with staged=1. They are stable for the whole action phase and through the following scan phase.
- w_STAGED = staged register.
- All pulse outputs are registered and last exactly one cycle.
- Counter width is clog2(WORD_W). Bits beyond WORD_W cannot occur, because the frame closes at WORD_W-1.

Test Plan:
1. Defaults, scan with SOW+CAPTURE, word 0x00006009 LSB-first over 32 strobes -> w_STAGED=1 after bit 31. Then raise w_HA -> b_LINE=9, b_FUNC=3, w_STAT_VALID single pulse, w_STAGED=0.
2. Two complete words 0x00006009 then 0x0000A01F before w_HA rise -> b_LINE=31, b_FUNC=5 (latest wins). Exactly one w_STAT_VALID.
3. Word 0x00006009, SOW reasserted at bit 10 with a fresh word 0x00002004 -> w_FRAME_ERR one pulse. After action: b_LINE=4, b_FUNC=1.
4. w_HA rises at bit 20 of a word, with nothing previously staged -> w_FRAME_ERR and w_NO_WORD pulses. b_LINE/b_FUNC keep prior values. Bits strobed during w_HA=1 have no effect.
5. w_CAPTURE=0 on SOW for 0x0000E01F -> nothing staged, outputs unchanged. w_NO_WORD pulses at the next w_HA rise.
6. Assert w_RST asynchronously (between edges) mid-SHIFT and again during action with b_LINE=9 -> all outputs 0 immediately. A subsequent full word stages and transfers normally.

Source files
------------

// File: rtl/serial_staticisor.sv
// serial_staticisor
//   Assembles one framed, LSB-first serial word during the scan phase
//   (w_HA=0). It extracts the line and function fields into a staging
//   register. On the rising edge of w_HA the staged fields move to static
//   outputs, which then hold until the next rise that finds a word staged.
//
// Ports
//   w_CLK, w_RST     clock, asynchronous active-high reset
//   w_HA             phase: 0 = scan (accept bits), 1 = action (hold outputs)
//   w_BIT_VALID      serial bit strobe, one bit per asserted cycle
//   w_BIT            serial data bit, LSB first
//   w_SOW            start-of-word, qualifies bit 0
//   w_CAPTURE        with w_SOW: this word is to be staticised
//   b_LINE, b_FUNC   staticised line / function fields
//   w_STAT_VALID     1-cycle pulse: outputs updated
//   w_STAGED         level: complete word waiting in staging
//   w_FRAME_ERR      1-cycle pulse: word aborted
//   w_NO_WORD        1-cycle pulse: action began with nothing staged
module serial_staticisor #(
   parameter int WORD_W   = 32,
   parameter int LINE_LSB = 0,
   parameter int LINE_W   = 5,
   parameter int FUNC_LSB = 13,
   parameter int FUNC_W   = 3
) (
   input  logic              w_CLK,
   input  logic              w_RST,
   input  logic              w_HA,
   input  logic              w_BIT_VALID,
   input  logic              w_BIT,
   input  logic              w_SOW,
   input  logic              w_CAPTURE,
   output logic [LINE_W-1:0] b_LINE,
   output logic [FUNC_W-1:0] b_FUNC,
   output logic              w_STAT_VALID,
   output logic              w_STAGED,
   output logic              w_FRAME_ERR,
   output logic              w_NO_WORD
);

   localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WORD_W-1:0]   shift_q, shift_d, word_c;
   logic [LINE_W-1:0]   stg_line_q;
   logic [FUNC_W-1:0]   stg_func_q;
   logic                staged_q, ha_d;
   logic                load, ferr_d;
   logic                accept, ha_rise;

   assign accept  = ~w_HA & w_BIT_VALID;
   assign ha_rise = w_HA & ~ha_d;

   // Current word with the incoming bit already merged, so the last bit
   // takes part in field extraction on the same edge.
   always_comb begin
      word_c         = shift_q;
      word_c[cnt_q]  = w_BIT;
   end

   always_ff @(posedge w_CLK or posedge w_RST) begin
      if (w_RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      load    = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept && w_SOW && w_CAPTURE) begin
               shift_d[0] = w_BIT;
               cnt_d      = CNT_W'(1);
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            if (w_HA) begin
               // Action phase began mid-word: drop the partial word.
               ferr_d  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else if (accept) begin
               if (w_SOW) begin
                  ferr_d = 1'b1;
                  if (w_CAPTURE) begin
                     shift_d[0] = w_BIT;
                     cnt_d      = CNT_W'(1);
                  end else begin
                     cnt_d   = '0;
                     state_d = IDLE;
                  end
               end else begin
                  shift_d = word_c;
                  if (cnt_q == CNT_W'(WORD_W-1)) begin
                     load    = 1'b1;
                     cnt_d   = '0;
                     state_d = IDLE;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Staging and static outputs. Completion and ha_rise are exclusive
   // because no bits are accepted while w_HA is high.
   always_ff @(posedge w_CLK or posedge w_RST) begin
      if (w_RST) begin
         ha_d         <= 1'b0;
         stg_line_q   <= '0;
         stg_func_q   <= '0;
         staged_q     <= 1'b0;
         b_LINE       <= '0;
         b_FUNC       <= '0;
         w_STAT_VALID <= 1'b0;
         w_FRAME_ERR  <= 1'b0;
         w_NO_WORD    <= 1'b0;
      end else begin
         ha_d         <= w_HA;
         w_STAT_VALID <= ha_rise & staged_q;
         w_NO_WORD    <= ha_rise & ~staged_q;
         w_FRAME_ERR  <= ferr_d;
         if (load) begin
            stg_line_q <= word_c[LINE_LSB +: LINE_W];
            stg_func_q <= word_c[FUNC_LSB +: FUNC_W];
            staged_q   <= 1'b1;
         end else if (ha_rise && staged_q) begin
            b_LINE   <= stg_line_q;
            b_FUNC   <= stg_func_q;
            staged_q <= 1'b0;
         end
      end
   end

   assign w_STAGED = staged_q;

endmodule

// File: tb/tb_serial_staticisor.sv
module tb_serial_staticisor;

   localparam int WORD_W = 32;

   logic       w_CLK = 1'b0;
   logic       w_RST, w_HA, w_BIT_VALID, w_BIT, w_SOW, w_CAPTURE;
   logic [4:0] b_LINE;
   logic [2:0] b_FUNC;
   logic       w_STAT_VALID, w_STAGED, w_FRAME_ERR, w_NO_WORD;

   serial_staticisor dut (
      .w_CLK(w_CLK), .w_RST(w_RST), .w_HA(w_HA), .w_BIT_VALID(w_BIT_VALID),
      .w_BIT(w_BIT), .w_SOW(w_SOW), .w_CAPTURE(w_CAPTURE),
      .b_LINE(b_LINE), .b_FUNC(b_FUNC), .w_STAT_VALID(w_STAT_VALID),
      .w_STAGED(w_STAGED), .w_FRAME_ERR(w_FRAME_ERR), .w_NO_WORD(w_NO_WORD)
   );

   always #5 w_CLK = ~w_CLK;

   typedef struct {logic [4:0] line; logic [2:0] func;} exp_t;
   exp_t exp_q[$];
   logic [4:0] exp_line;
   logic [2:0] exp_func;

   int tests = 0, fails = 0;
   int n_sv = 0, n_fe = 0, n_nw = 0;
   logic p_sv = 0, p_fe = 0, p_nw = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulse monitor: count pulses and require each to last one cycle.
   always @(negedge w_CLK) begin
      if (w_STAT_VALID) begin n_sv++; chk("sv_width", {31'b0, p_sv}, 32'd0); end
      if (w_FRAME_ERR)  begin n_fe++; chk("fe_width", {31'b0, p_fe}, 32'd0); end
      if (w_NO_WORD)    begin n_nw++; chk("nw_width", {31'b0, p_nw}, 32'd0); end
      p_sv = w_STAT_VALID; p_fe = w_FRAME_ERR; p_nw = w_NO_WORD;
   end

   task automatic tick();
      @(posedge w_CLK);
      #1;
   endtask

   // Drive bits [first..last] of a word; SOW on bit 0.
   task automatic send_bits(input logic [31:0] w, input logic cap, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         w_BIT_VALID = 1'b1;
         w_BIT       = w[i];
         w_SOW       = (i == 0);
         w_CAPTURE   = cap;
         tick();
      end
      w_BIT_VALID = 1'b0;
      w_SOW       = 1'b0;
      w_CAPTURE   = 1'b0;
   endtask

   // Scoreboard push for a word that will complete and be captured:
   // only the latest staged word survives.
   task automatic push_word(input logic [31:0] w);
      exp_t e;
      e.line = w[4:0];
      e.func = w[15:13];
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      exp_q.push_back(e);
   endtask

   task automatic action(input string tag);
      int sv0, nw0;
      exp_t e;
      sv0 = n_sv; nw0 = n_nw;
      w_HA = 1'b1;
      tick();
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         exp_line = e.line; exp_func = e.func;
         chk({tag, "_sv_now"}, {31'b0, w_STAT_VALID}, 32'd1);
      end else begin
         chk({tag, "_nw_now"}, {31'b0, w_NO_WORD}, 32'd1);
      end
      chk({tag, "_line"}, {27'b0, b_LINE}, {27'b0, exp_line});
      chk({tag, "_func"}, {29'b0, b_FUNC}, {29'b0, exp_func});
      chk({tag, "_staged"}, {31'b0, w_STAGED}, 32'd0);
      repeat (3) tick();
      chk({tag, "_sv_cnt"}, n_sv - sv0, (exp_q.size() == 0 && w_NO_WORD == 0 && n_nw == nw0) ? 32'd1 : 32'd0);
      w_HA = 1'b0;
      tick();
      chk({tag, "_line_hold"}, {27'b0, b_LINE}, {27'b0, exp_line});
   endtask

   task automatic do_reset();
      w_RST = 1'b1;
      #1;
      chk("rst_line", {27'b0, b_LINE}, 32'd0);
      chk("rst_func", {29'b0, b_FUNC}, 32'd0);
      chk("rst_staged", {31'b0, w_STAGED}, 32'd0);
      chk("rst_pulses", {29'b0, w_STAT_VALID, w_FRAME_ERR, w_NO_WORD}, 32'd0);
      exp_q.delete();
      exp_line = '0; exp_func = '0;
   endtask

   initial begin
      int fe0, nw0, sv0;
      w_RST = 1'b0; w_HA = 1'b0; w_BIT_VALID = 1'b0; w_BIT = 1'b0;
      w_SOW = 1'b0; w_CAPTURE = 1'b0;
      #2;
      do_reset();
      repeat (2) tick();
      w_RST = 1'b0;
      tick();

      // 1: single word
      send_bits(32'h0000_6009, 1'b1, 0, WORD_W-2);
      chk("t1_not_staged_early", {31'b0, w_STAGED}, 32'd0);
      send_bits(32'h0000_6009, 1'b1, WORD_W-1, WORD_W-1);
      // last bit driven without SOW: resend as continuation
      chk("t1_staged", {31'b0, w_STAGED}, 32'd1);
      push_word(32'h0000_6009);
      action("t1");
      chk("t1_line9", {27'b0, b_LINE}, 32'd9);
      chk("t1_func3", {29'b0, b_FUNC}, 32'd3);

      // 2: latest word wins
      sv0 = n_sv;
      send_bits(32'h0000_6009, 1'b1, 0, WORD_W-1); push_word(32'h0000_6009);
      send_bits(32'h0000_A01F, 1'b1, 0, WORD_W-1); push_word(32'h0000_A01F);
      chk("t2_staged", {31'b0, w_STAGED}, 32'd1);
      action("t2");
      chk("t2_line31", {27'b0, b_LINE}, 32'd31);
      chk("t2_func5", {29'b0, b_FUNC}, 32'd5);
      chk("t2_one_sv", n_sv - sv0, 32'd1);

      // 3: premature SOW restarts with a fresh word
      fe0 = n_fe;
      send_bits(32'h0000_6009, 1'b1, 0, 9);
      send_bits(32'h0000_2004, 1'b1, 0, WORD_W-1); push_word(32'h0000_2004);
      tick();
      chk("t3_fe", n_fe - fe0, 32'd1);
      action("t3");
      chk("t3_line4", {27'b0, b_LINE}, 32'd4);
      chk("t3_func1", {29'b0, b_FUNC}, 32'd1);

      // 4: action begins mid-word, nothing staged; strobes during HA ignored
      fe0 = n_fe; nw0 = n_nw;
      send_bits(32'h0000_E01F, 1'b1, 0, 19);
      w_HA = 1'b1;
      for (int i = 0; i < 6; i++) begin
         w_BIT_VALID = 1'b1; w_BIT = 1'b1; w_SOW = (i == 2); w_CAPTURE = 1'b1;
         tick();
      end
      w_BIT_VALID = 1'b0; w_SOW = 1'b0; w_CAPTURE = 1'b0;
      chk("t4_fe", n_fe - fe0, 32'd1);
      chk("t4_nw", n_nw - nw0, 32'd1);
      chk("t4_line_kept", {27'b0, b_LINE}, 32'd4);
      chk("t4_func_kept", {29'b0, b_FUNC}, 32'd1);
      w_HA = 1'b0;
      repeat (2) tick();
      chk("t4_not_staged", {31'b0, w_STAGED}, 32'd0);

      // 5: capture not requested
      nw0 = n_nw;
      send_bits(32'h0000_E01F, 1'b0, 0, WORD_W-1);
      chk("t5_not_staged", {31'b0, w_STAGED}, 32'd0);
      action("t5");
      chk("t5_nw", n_nw - nw0, 32'd1);
      chk("t5_line_kept", {27'b0, b_LINE}, 32'd4);

      // 6: async reset mid-shift, then mid-action
      send_bits(32'h0000_6009, 1'b1, 0, 9);
      #2;
      do_reset();
      tick();
      w_RST = 1'b0;
      tick();
      send_bits(32'h0000_6009, 1'b1, 0, WORD_W-1); push_word(32'h0000_6009);
      w_HA = 1'b1;
      tick();
      chk("t6_line9", {27'b0, b_LINE}, 32'd9);
      exp_q.delete();
      #2;
      do_reset();
      w_HA = 1'b0;
      tick();
      w_RST = 1'b0;
      tick();
      send_bits(32'h0000_A01F, 1'b1, 0, WORD_W-1); push_word(32'h0000_A01F);
      chk("t6_staged", {31'b0, w_STAGED}, 32'd1);
      action("t6");
      chk("t6_line31", {27'b0, b_LINE}, 32'd31);
      chk("t6_func5", {29'b0, b_FUNC}, 32'd5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
